// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: next-PC select codes, IFU states and
// the default fetch window base.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          ADDR_W_DEFAULT   = 10;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_JMP = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } ifu_state_e;

    // Branch displacement: signed word offset converted to a byte offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        logic signed [31:0] off;
        off = {{14{imm[15]}}, imm, 2'b00};
        return $unsigned(off);
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection plus legality check against the
// instruction memory window.
module npc_calc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic [31:0] i_pc,
    input  logic [1:0]  i_npc_sel,
    input  logic        i_br_taken,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_npc,
    output logic        o_npc_bad
);

    localparam logic [31:0] WIN_BYTES = 32'd4 << ADDR_W;

    npc_sel_e    w_sel;
    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_offset;

    assign w_sel    = npc_sel_e'(i_npc_sel);
    assign w_pc4    = i_pc + 32'd4;
    assign w_br_tgt = w_pc4 + br_offset(i_imm16);

    always_comb begin
        o_npc = w_pc4;
        case (w_sel)
            NPC_SEQ: o_npc = w_pc4;
            NPC_BR:  o_npc = i_br_taken ? w_br_tgt : w_pc4;
            NPC_JMP: o_npc = {w_pc4[31:28], i_imm26, 2'b00};
            NPC_JR:  o_npc = i_jr_target;
            default: o_npc = w_pc4;
        endcase
    end

    // Offset wraps modulo 2^32, so one unsigned compare covers both
    // below-base and past-end targets.
    assign w_offset  = o_npc - RESET_PC;
    assign o_npc_bad = (o_npc[1:0] != 2'b00) || (w_offset >= WIN_BYTES);

endmodule

// File: rtl/ifu_pc.sv
// Instruction fetch unit: program counter, IF/ID register and the
// RUN/HALT fetch-fault state machine.
module ifu_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        npc_sel,
    input  logic              br_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [31:0]       jr_target,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       pc,
    output logic [31:0]       ir,
    output logic [31:0]       ir_pc,
    output logic              ir_valid,
    output logic              fault
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_ir_pc;
    logic        r_ir_valid;

    logic [31:0] w_npc;
    logic        w_npc_bad;
    logic        w_pc_ld;
    logic        w_ir_ld;
    logic        w_ir_clr;

    npc_calc #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_npc_calc (
        .i_pc        (r_pc),
        .i_npc_sel   (npc_sel),
        .i_br_taken  (br_taken),
        .i_imm16     (imm16),
        .i_imm26     (imm26),
        .i_jr_target (jr_target),
        .o_npc       (w_npc),
        .o_npc_bad   (w_npc_bad)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An illegal target still latches the current instruction; only the
    // PC update is suppressed, and ir_valid drops one edge later.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_ld     = 1'b0;
        w_ir_ld     = 1'b0;
        w_ir_clr    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_ir_ld = 1'b1;
                    if (w_npc_bad) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_ld = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                w_ir_clr = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_ir_pc    <= 32'd0;
            r_ir_valid <= 1'b0;
        end else begin
            if (w_pc_ld) begin
                r_pc <= w_npc;
            end
            if (w_ir_ld) begin
                r_ir       <= imem_data;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
            end else if (w_ir_clr) begin
                r_ir_valid <= 1'b0;
            end
        end
    end

    // Window base is word aligned, so the word index can be formed from
    // the address bits alone.
    assign addr     = r_pc[ADDR_W+1:2] - RESET_PC[ADDR_W+1:2];
    assign pc       = r_pc;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign ir_valid = r_ir_valid;
    assign fault    = (r_state == ST_HALT);

endmodule

// File: doc/ifu_pc.md
IFU_PC -- requirements
Module: ifu_pc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, first fetch address and base of instruction memory window.
REQ-002 Parameter ADDR_W, default 10, word-address width driven to instruction memory (1024 words).
REQ-003 clk  input  1  rising-edge clock; one clock domain.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 stall  input  1  high holds PC and IF/ID register.
REQ-006 npc_sel  input  2  next-PC select: 0 sequential, 1 branch, 2 jump imm26, 3 jump register.
REQ-007 br_taken  input  1  branch condition; used only when npc_sel=1.
REQ-008 imm16  input  16  branch offset in words, signed.
REQ-009 imm26  input  26  jump target field.
REQ-010 jr_target  input  32  register jump target.
REQ-011 imem_data  input  32  instruction word from combinational instruction memory for addr.
REQ-012 addr  output  ADDR_W  word address to instruction memory.
REQ-013 pc  output  32  current fetch PC.
REQ-014 ir  output  32  registered instruction (IF/ID).
REQ-015 ir_pc  output  32  PC of ir.
REQ-016 ir_valid  output  1  ir holds a fetched instruction.
REQ-017 fault  output  1  sticky: PC left window or became misaligned; fetch halted.

Function
REQ-018 addr SHALL equal (pc - RESET_PC)[ADDR_W+1:2], combinational.
REQ-019 pc4 = pc + 4; next PC SHALL be: sel 0 -> pc4; sel 1 -> br_taken ? pc4 + (sign-extended imm16 << 2) : pc4; sel 2 -> {pc4[31:28], imm26, 2'b00}; sel 3 -> jr_target.
REQ-020 All PC arithmetic SHALL be modulo 2^32; no carry out.
REQ-021 FSM states SHALL be RUN and HALT; reset enters RUN.
REQ-022 In RUN with stall=0, each edge SHALL load pc<=next PC, ir<=imem_data, ir_pc<=pc, ir_valid<=1.
REQ-023 In RUN with stall=1, pc, ir, ir_pc, ir_valid SHALL hold; npc_sel ignored that cycle.
REQ-024 Control transfer takes effect on the edge it is presented; the instruction at pc4 is not fetched by the IFU if the transfer target differs (delay slot is ir already latched, no flush).
REQ-025 A computed next PC that is misaligned (bits[1:0]!=0) or outside [RESET_PC, RESET_PC + 4*2^ADDR_W) SHALL, when stall=0, transition to HALT instead of loading pc; ir/ir_pc load normally that edge.
REQ-026 In HALT, pc SHALL hold, ir_valid SHALL be 0 from the next edge, fault SHALL be 1; only reset exits HALT.
REQ-027 stall=1 concurrent with an illegal next PC SHALL not trigger HALT.
REQ-028 Sequential fetch at the last window word SHALL trigger HALT (no wrap-around).

Reset
REQ-029 On a clk edge with reset=0: pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, fault=0, state=RUN; reset overrides stall.
REQ-030 Reset mid-operation (including in HALT) SHALL take effect on that edge with no residual state.

Structure
REQ-031 npc_sel encodings, RESET_PC default and FSM state encodings SHALL live in shared package cpu_pkg.
REQ-032 Next-PC computation SHALL be a combinational sub-module npc_calc; ifu_pc holds registers and FSM.

Verification
REQ-033 Reset, release, npc_sel=0 for 3 cycles -> pc 3000,3004,3008,300C; addr 0,1,2,3; ir_valid=1 after first edge.
REQ-034 pc=3010, npc_sel=1, br_taken=1, imm16=16'hFFFC -> next pc=3004; br_taken=0 -> 3014.
REQ-035 pc=3008, npc_sel=2, imm26=26'h0000C10 -> next pc=3040; npc_sel=3, jr_target=3100 -> 3100.
REQ-036 stall=1 for 2 cycles at pc=3008 -> pc, ir, ir_pc unchanged; resumes 300C after release.
REQ-037 npc_sel=3, jr_target=3102 -> fault=1, pc holds, ir_valid=0 next cycle; same with stall=1 -> no fault.
REQ-038 In HALT assert reset=0 one cycle -> pc=3000, fault=0, normal fetch resumes.
